// File: rtl/fifo_rd_uart_tx.sv
// FIFO read-side drain: pops words from the async FIFO read port and sends each
// one as a UART frame (start, DSIZE data bits LSB first, optional even parity, stop bits).
module fifo_rd_uart_tx #(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DSIZE > 2) ? $clog2(DSIZE) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DSIZE - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DSIZE-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic bit_end;
    logic last_stop;
    logic ld;

    assign bit_end   = (state_q != IDLE) && (baud_q == BAUD_LAST);
    assign last_stop = (state_q == STOP) && (bit_q == STOP_LAST) && bit_end;
    // rrst gating keeps the pop strobe quiet while reset is held, even though state reads IDLE.
    assign ld        = rrst && en && !rempty && ((state_q == IDLE) || last_stop);

    assign rinc       = ld;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = last_stop;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        busy_d  = busy_q;
        txd_d   = 1'b1;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A load overrides the end-of-frame return to IDLE, giving zero-gap back-to-back frames.
        if (ld) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = rdata;
            par_d   = ^rdata;
            busy_d  = 1'b1;
        end

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

endmodule
